// File: rtl/urv_timer_cmp.sv
// urv_timer_cmp: timer compare and interrupt unit.
// Compares csr_time_i against cmp; supports one-shot and periodic modes.
module urv_timer_cmp #(
  parameter int g_time_width   = 40,
  parameter int g_period_width = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [g_time_width-1:0] csr_time_i,
  input  logic                    wr_i,
  input  logic                    rd_i,
  input  logic [1:0]              addr_i,
  input  logic [31:0]             data_i,
  output logic [31:0]             rd_data_o,
  output logic                    irq_o
);

  localparam int HW = g_time_width - 32;
  localparam int PW = g_period_width;

  localparam logic [1:0] A_LO   = 2'd0;
  localparam logic [1:0] A_HI   = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } st_t;

  st_t                    state;
  st_t                    state_n;
  logic [g_time_width-1:0] cmp;
  logic [g_time_width-1:0] cmp_n;
  logic [31:0]            lo_stage;
  logic [31:0]            lo_stage_n;
  logic                   en;
  logic                   en_n;
  logic                   per_mode;
  logic                   per_mode_n;
  logic [PW-1:0]          period;
  logic [PW-1:0]          period_n;
  logic                   pending;
  logic                   pending_n;
  logic                   overrun;
  logic                   overrun_n;
  logic [7:0]             missed;
  logic [7:0]             missed_n;
  logic [31:0]            rd_data;
  logic [31:0]            rd_data_n;
  logic [31:0]            rd_val;

  logic commit;
  logic ctrl_wr;
  logic stat_wr;
  logic clr_pend;
  logic clr_ovr;
  logic hit;
  logic reload;
  logic lost;

  assign commit   = wr_i && (addr_i == A_HI);
  assign ctrl_wr  = wr_i && (addr_i == A_CTRL);
  assign stat_wr  = wr_i && (addr_i == A_STAT);
  assign clr_pend = stat_wr && data_i[0];
  assign clr_ovr  = stat_wr && data_i[1];

  // All-ones compare is the "never" value even though time can reach it.
  assign hit = (state == ARMED)
            && !commit
            && !ctrl_wr
            && (cmp != '1)
            && (csr_time_i >= cmp);

  assign reload = per_mode && (period != '0);
  assign lost   = hit && pending && !clr_pend;

  always_comb begin
    rd_val = '0;
    unique case (addr_i)
      A_LO:   rd_val = cmp[31:0];
      A_HI:   rd_val = 32'(cmp[g_time_width-1:32]);
      A_CTRL: rd_val = 32'({period, 6'b0, per_mode, en});
      A_STAT: rd_val = {14'b0, state, missed,
                        6'b0, overrun, pending};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_n    = state;
    cmp_n      = cmp;
    lo_stage_n = lo_stage;
    en_n       = en;
    per_mode_n = per_mode;
    period_n   = period;
    pending_n  = pending;
    overrun_n  = overrun;
    missed_n   = missed;
    rd_data_n  = rd_i ? rd_val : rd_data;

    if (wr_i && (addr_i == A_LO))
      lo_stage_n = data_i;

    if (commit)
      cmp_n = {data_i[HW-1:0], lo_stage};
    else if (hit && reload)
      cmp_n = cmp + g_time_width'(period);

    if (ctrl_wr) begin
      en_n       = data_i[0];
      per_mode_n = data_i[1];
      period_n   = data_i[8 +: PW];
    end

    if (hit)
      pending_n = 1'b1;
    else if (clr_pend)
      pending_n = 1'b0;

    if (lost) begin
      overrun_n = 1'b1;
      missed_n  = (missed != 8'hFF) ? missed + 8'd1 : missed;
    end else if (clr_ovr) begin
      overrun_n = 1'b0;
      missed_n  = '0;
    end

    if (ctrl_wr) begin
      state_n = data_i[0] ? ARMED : IDLE;
    end else begin
      unique case (state)
        IDLE:    state_n = IDLE;
        ARMED:   if (hit && !reload) state_n = DONE;
        DONE:    if (commit) state_n = ARMED;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cmp      <= '1;
      lo_stage <= '0;
      en       <= 1'b0;
      per_mode <= 1'b0;
      period   <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      missed   <= '0;
      rd_data  <= '0;
    end else begin
      state    <= state_n;
      cmp      <= cmp_n;
      lo_stage <= lo_stage_n;
      en       <= en_n;
      per_mode <= per_mode_n;
      period   <= period_n;
      pending  <= pending_n;
      overrun  <= overrun_n;
      missed   <= missed_n;
      rd_data  <= rd_data_n;
    end
  end

  assign irq_o     = pending;
  assign rd_data_o = rd_data;

endmodule

// File: tb/tb_urv_timer_cmp.sv
// tb_urv_timer_cmp: scoreboard bench for the timer compare unit.
// Read expectations are queued at drive time and checked when data returns.
module tb_urv_timer_cmp;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [39:0] tm = '0;
  logic        wr_i = 1'b0;
  logic        rd_i = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] data = '0;
  logic [31:0] rd_data;
  logic        irq;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] v;
    logic [1:0]  a;
  } exp_t;

  exp_t sb[$];
  logic rv = 1'b0;

  urv_timer_cmp dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .csr_time_i (tm),
    .wr_i       (wr_i),
    .rd_i       (rd_i),
    .addr_i     (addr),
    .data_i     (data),
    .rd_data_o  (rd_data),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) rv <= rd_i;

  always @(negedge clk) begin
    if (rv) begin
      check("sb_avail", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("rd_a%0d", e.a), 64'(rd_data), 64'(e.v));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    wr_i = 1'b0;
    rd_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_i = 1'b1;
    addr = a;
    data = d;
    cyc();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    rd_i = 1'b1;
    addr = a;
    sb.push_back('{v: e, a: a});
    cyc();
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_i = 1'b1;
      addr = 2'd2;
      data = 32'h1;
      cyc();
    end
    rst_i = 1'b1;
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_rdata", 64'(rd_data), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // reset state and the never-matching all-ones compare
    do_reset();
    rd(2'd3, 32'h0);
    rd(2'd1, 32'hFF);
    rd(2'd0, 32'hFFFF_FFFF);
    wr(2'd2, 32'h1);
    tm = '1;
    cyc();
    cyc();
    check("ones_nomatch", 64'(irq), 64'(0));

    // one-shot
    do_reset();
    tm = '0;
    wr(2'd0, 32'd100);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'h1);
    for (int t = 95; t <= 105; t++) begin
      tm = 40'(t);
      cyc();
      check($sformatf("os_irq_t%0d", t), 64'(irq), 64'(t >= 100));
    end
    rd(2'd3, 32'h0002_0001);
    wr(2'd3, 32'h1);
    check("os_w1c", 64'(irq), 64'(0));
    for (int t = 106; t <= 110; t++) begin
      tm = 40'(t);
      cyc();
    end
    check("os_norefire", 64'(irq), 64'(0));
    rd(2'd3, 32'h0002_0000);
    wr(2'd0, 32'd200);
    wr(2'd1, 32'd0);
    rd(2'd3, 32'h0001_0000);
    tm = 40'd200;
    cyc();
    check("os_rearm", 64'(irq), 64'(1));
    rd(2'd3, 32'h0002_0001);

    // periodic
    do_reset();
    tm = '0;
    wr(2'd0, 32'd100);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'h0000_0A03);
    rd(2'd2, 32'h0000_0A03);
    for (int t = 95; t <= 125; t++) begin
      tm = 40'(t);
      if (t == 101 || t == 111 || t == 121) begin
        wr_i = 1'b1;
        addr = 2'd3;
        data = 32'h1;
      end else if (t == 102 || t == 112 || t == 122) begin
        rd_i = 1'b1;
        addr = 2'd0;
        sb.push_back('{v: 32'(t + 8), a: 2'd0});
      end
      cyc();
      check($sformatf("per_irq_t%0d", t), 64'(irq),
            64'(t == 100 || t == 110 || t == 120));
    end
    rd(2'd3, 32'h0001_0000);

    // overrun and missed saturation
    do_reset();
    tm = 40'd50;
    wr(2'd0, 32'd100);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'h0000_0103);
    for (int i = 0; i < 4; i++) begin
      tm = 40'(100 + i);
      cyc();
    end
    check("ovr_irq", 64'(irq), 64'(1));
    rd(2'd3, 32'h0001_0303);
    for (int i = 0; i < 296; i++) begin
      tm = 40'(104 + i);
      cyc();
    end
    rd(2'd3, 32'h0001_FF03);
    rd(2'd0, 32'd400);
    wr(2'd3, 32'h3);
    rd(2'd3, 32'h0001_0000);

    // atomic compare update
    do_reset();
    tm = 40'h00_FFFF_FFF0;
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h1);
    wr(2'd2, 32'h1);
    cyc();
    cyc();
    check("atom_nofire", 64'(irq), 64'(0));
    wr(2'd0, 32'h10);
    check("atom_lo_only", 64'(irq), 64'(0));
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h1);
    wr(2'd1, 32'h0);
    check("atom_commit_cyc", 64'(irq), 64'(0));
    cyc();
    check("atom_fire", 64'(irq), 64'(1));
    rd(2'd0, 32'h10);

    // collisions
    do_reset();
    tm = '0;
    wr(2'd0, 32'd10);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'h0000_0103);
    tm = 40'd10;
    cyc();
    check("col_fire", 64'(irq), 64'(1));
    tm = 40'd11;
    wr(2'd3, 32'h1);
    check("col_w1c_match", 64'(irq), 64'(1));
    rd(2'd3, 32'h0001_0001);
    wr(2'd2, 32'h0);
    check("col_dis_keep", 64'(irq), 64'(1));
    rd(2'd3, 32'h0000_0001);
    wr(2'd3, 32'h1);
    check("col_clear", 64'(irq), 64'(0));
    tm = 40'd20;
    cyc();
    cyc();
    cyc();
    check("col_idle_nofire", 64'(irq), 64'(0));
    rd(2'd3, 32'h0);
    wr_i = 1'b1;
    rd_i = 1'b1;
    addr = 2'd2;
    data = 32'h0000_0501;
    sb.push_back('{v: 32'h0, a: 2'd2});
    cyc();
    rd(2'd2, 32'h0000_0501);

    cyc();
    cyc();
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
